// File: rtl/rf_wb_ctrl_if.sv
// rtl/rf_wb_ctrl_if.sv - ALU/LSU result inputs and register-file write port bundle for rf_wb_ctrl
interface rf_wb_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [4:0]    mem_rd;
    logic [31:0]   mem_data;
    logic          WE3;
    logic [4:0]    A3;
    logic [31:0]   WD3;
    logic [31:0]   pending;
    logic [CW-1:0] fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  mem_ready, WE3, A3, WD3, pending, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output mem_ready, WE3, A3, WD3, pending, fifo_count
    );
endinterface

// File: rtl/rf_wb_ctrl.sv
// rtl/rf_wb_ctrl.sv - register-file writeback arbiter, ALU priority over FIFO-buffered LSU results
// Optional pending-write scoreboard is built when RF_WB_SCOREBOARD_EN is defined.
module rf_wb_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    rf_wb_ctrl_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          alu_take;
    logic          push;
    logic          pop;
    logic          we_q;
    logic [4:0]    a3_q;
    logic [31:0]   wd3_q;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign alu_take = bus.alu_valid && (bus.alu_rd != 5'd0);
    // x0 handshakes are consumed but never enter the FIFO
    assign push     = bus.mem_valid && !full && (bus.mem_rd != 5'd0);
    assign pop      = !alu_take && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= bus.mem_rd;
            data_mem[wr_ptr] <= bus.mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            we_q   <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (alu_take) begin
                we_q  <= 1'b1;
                a3_q  <= bus.alu_rd;
                wd3_q <= bus.alu_data;
            end else if (pop) begin
                we_q  <= 1'b1;
                a3_q  <= rd_mem[rd_ptr];
                wd3_q <= data_mem[rd_ptr];
            end else begin
                we_q  <= 1'b0;
            end
        end
    end

    assign bus.mem_ready  = !full;
    assign bus.WE3        = we_q;
    assign bus.A3         = a3_q;
    assign bus.WD3        = wd3_q;
    assign bus.fifo_count = count;

`ifdef RF_WB_SCOREBOARD_EN
    logic [PW-1:0] slot_off;
    logic [31:0]   pend;

    // A slot is live when its distance from the read pointer is below count
    always_comb begin
        pend     = '0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PW'(i) - rd_ptr;
            if ({1'b0, slot_off} < count) pend[rd_mem[i]] = 1'b1;
        end
        if (we_q) pend[a3_q] = 1'b1;
    end

    assign bus.pending = pend;
`else
    assign bus.pending = 32'h0;
`endif
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb/tb_rf_wb_ctrl.sv - directed self-checking bench for rf_wb_ctrl
module tb_rf_wb_ctrl;
`ifdef RF_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rf_wb_ctrl_if #(.DEPTH(4)) bus ();
    rf_wb_ctrl #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] pexp(input logic [31:0] v);
        return SB ? v : 32'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got %b exp 0", bus.WE3); end
        checks++; if (bus.A3 !== 5'd0) begin errors++; $display("FAIL reset_a3 got %0d exp 0", bus.A3); end
        checks++; if (bus.WD3 !== 32'h0) begin errors++; $display("FAIL reset_wd3 got %h exp 0", bus.WD3); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.fifo_count); end
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", bus.pending); end
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.mem_ready); end
    endtask

    task automatic test_alu_single();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        step();
        bus.alu_valid = 1'b0;
        checks++; if (bus.WE3 !== 1'b1) begin errors++; $display("FAIL alu_we3 got %b exp 1", bus.WE3); end
        checks++; if (bus.A3 !== 5'd5) begin errors++; $display("FAIL alu_a3 got %0d exp 5", bus.A3); end
        checks++; if (bus.WD3 !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wd3 got %h exp deadbeef", bus.WD3); end
        checks++; if (bus.pending !== pexp(32'h20)) begin errors++; $display("FAIL alu_pending got %h exp %h", bus.pending, pexp(32'h20)); end
        step();
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL alu_we3_off got %b exp 0", bus.WE3); end
        checks++; if (bus.A3 !== 5'd5) begin errors++; $display("FAIL alu_a3_hold got %0d exp 5", bus.A3); end
    endtask

    task automatic test_x0_discard();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
        step();
        bus.alu_valid = 1'b0;
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL x0_alu_we3 got %b exp 0", bus.WE3); end
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h5678;
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", bus.mem_ready); end
        step();
        bus.mem_valid = 1'b0;
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL x0_count got %0d exp 0", bus.fifo_count); end
        step();
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL x0_mem_we3 got %b exp 0", bus.WE3); end
    endtask

    task automatic test_lsu_latency();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h33;
        step();
        bus.mem_valid = 1'b0;
        checks++; if (bus.WE3 !== 1'b0 || bus.fifo_count !== 3'd1) begin errors++; $display("FAIL lsu_push got we=%b cnt=%0d exp we=0 cnt=1", bus.WE3, bus.fifo_count); end
        checks++; if (bus.pending !== pexp(32'h8)) begin errors++; $display("FAIL lsu_pend_q got %h exp %h", bus.pending, pexp(32'h8)); end
        step();
        checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd3 || bus.WD3 !== 32'h33) begin errors++; $display("FAIL lsu_write got we=%b a3=%0d wd=%h exp 1/3/33", bus.WE3, bus.A3, bus.WD3); end
        checks++; if (bus.fifo_count !== 3'd0 || bus.pending !== pexp(32'h8)) begin errors++; $display("FAIL lsu_staged got cnt=%0d pend=%h exp 0/%h", bus.fifo_count, bus.pending, pexp(32'h8)); end
        step();
        checks++; if (bus.WE3 !== 1'b0 || bus.pending !== 32'h0) begin errors++; $display("FAIL lsu_done got we=%b pend=%h exp 0/0", bus.WE3, bus.pending); end
    endtask

    task automatic test_fifo_fill();
        for (int k = 0; k < 4; k++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'(k + 1); bus.alu_data = 32'(k + 1);
            bus.mem_valid = 1'b1; bus.mem_rd = 5'(8 + k); bus.mem_data = 32'h100 + 32'(8 + k);
            step();
            checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'(k + 1)) begin errors++; $display("FAIL fill_alu%0d got we=%b a3=%0d exp 1/%0d", k, bus.WE3, bus.A3, k + 1); end
        end
        checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", bus.fifo_count); end
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", bus.mem_ready); end
        checks++; if (bus.pending !== pexp(32'h0F10)) begin errors++; $display("FAIL fill_pending got %h exp %h", bus.pending, pexp(32'h0F10)); end
        // offered while full with ALU still busy: not accepted
        bus.alu_rd = 5'd5; bus.alu_data = 32'h5; bus.mem_rd = 5'd12; bus.mem_data = 32'h10C;
        step();
        checks++; if (bus.fifo_count !== 3'd4 || bus.A3 !== 5'd5) begin errors++; $display("FAIL fill_stall got cnt=%0d a3=%0d exp 4/5", bus.fifo_count, bus.A3); end
        // pop while full: still no push
        bus.alu_valid = 1'b0;
        step();
        bus.mem_valid = 1'b0;
        checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop_nopush got %0d exp 3", bus.fifo_count); end
        checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd8 || bus.WD3 !== 32'h108) begin errors++; $display("FAIL drain0 got we=%b a3=%0d wd=%h exp 1/8/108", bus.WE3, bus.A3, bus.WD3); end
        for (int k = 1; k < 4; k++) begin
            step();
            checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'(8 + k) || bus.WD3 !== 32'h100 + 32'(8 + k)) begin errors++; $display("FAIL drain%0d got we=%b a3=%0d wd=%h exp a3=%0d", k, bus.WE3, bus.A3, bus.WD3, 8 + k); end
        end
        checks++; if (bus.pending !== pexp(32'h0800)) begin errors++; $display("FAIL drain_last_pend got %h exp %h", bus.pending, pexp(32'h0800)); end
        step();
        checks++; if (bus.WE3 !== 1'b0 || bus.pending !== 32'h0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL drain_end got we=%b pend=%h cnt=%0d exp 0/0/0", bus.WE3, bus.pending, bus.fifo_count); end
    endtask

    task automatic test_push_pop_wrap();
        logic [4:0] q[$];
        logic [4:0] exp_rd;
        for (int k = 0; k < 2; k++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h2;
            bus.mem_valid = 1'b1; bus.mem_rd = 5'(16 + k); bus.mem_data = 32'hC0DE0000 | 32'(16 + k);
            q.push_back(5'(16 + k));
            step();
        end
        bus.alu_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.mem_rd = 5'(18 + i); bus.mem_data = 32'hC0DE0000 | 32'(18 + i);
            q.push_back(5'(18 + i));
            exp_rd = q.pop_front();
            step();
            checks++; if (bus.fifo_count !== 3'd2) begin errors++; $display("FAIL wrap_count%0d got %0d exp 2", i, bus.fifo_count); end
            checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== exp_rd || bus.WD3 !== (32'hC0DE0000 | 32'(exp_rd))) begin errors++; $display("FAIL wrap_data%0d got a3=%0d wd=%h exp a3=%0d", i, bus.A3, bus.WD3, exp_rd); end
        end
        bus.mem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_rd = q.pop_front();
            step();
            checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== exp_rd || bus.WD3 !== (32'hC0DE0000 | 32'(exp_rd))) begin errors++; $display("FAIL wrap_tail%0d got a3=%0d wd=%h exp a3=%0d", i, bus.A3, bus.WD3, exp_rd); end
        end
        step();
        checks++; if (bus.WE3 !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL wrap_end got we=%b cnt=%0d exp 0/0", bus.WE3, bus.fifo_count); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
            bus.mem_valid = 1'b1; bus.mem_rd = 5'(20 + k); bus.mem_data = 32'(20 + k);
            step();
        end
        idle_inputs();
        checks++; if (bus.fifo_count !== 3'd3 || bus.WE3 !== 1'b1) begin errors++; $display("FAIL mid_setup got cnt=%0d we=%b exp 3/1", bus.fifo_count, bus.WE3); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.WE3 !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL mid_rst got we=%b cnt=%0d exp 0/0", bus.WE3, bus.fifo_count); end
        checks++; if (bus.pending !== 32'h0 || bus.mem_ready !== 1'b1) begin errors++; $display("FAIL mid_rst2 got pend=%h ready=%b exp 0/1", bus.pending, bus.mem_ready); end
        step();
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL mid_after got we=%b exp 0", bus.WE3); end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_x0_discard();
        test_lsu_latency();
        test_fifo_fill();
        test_push_pop_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
